adjust_mode_fsm: RTL and testbench

//  Parametrised mode/field-select controller for the alarm-clock front panel; generalises the fixed
//  5-enable FSM. Debounced button pulses move the clock between NORMAL and ADJUST, select one of
//  N_FIELDS editable fields (one-hot), and emit gated inc/dec pulses with hold-to-auto-repeat.

---
 rtl/clock_pkg.sv | 37 +++
 rtl/repeat_gen.sv | 83 ++++++++
 rtl/adjust_mode_fsm.sv | 191 +++++++++++++++++++
 tb/tb_adjust_mode_fsm.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Desc     : Shared types, default tick constants and helpers for the
//             alarm-clock front-panel mode/field-select controller.
//  Revision : 1.0  initial release
// ============================================================================
package clock_pkg;

  // Front-panel operating mode
  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    ADJUST = 1'b1
  } mode_t;

  // Default timebase constants (in ticks)
  localparam int unsigned C_TIMEOUT_TICKS_DEF = 1000;
  localparam int unsigned C_REPEAT_DELAY_DEF  = 50;
  localparam int unsigned C_REPEAT_RATE_DEF   = 10;

  // One-hot decode of idx into an n-wide vector (n <= 32); out-of-range idx gives zero
  function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned n);
    logic [31:0] v;
    v = '0;
    if ((idx < n) && (idx < 32)) begin
      v = 32'(1) << idx;
    end
    return v;
  endfunction

  // Larger of two unsigned values, used to size shared counters
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/repeat_gen.sv
`default_nettype none
// ============================================================================
//  Module   : repeat_gen
//  Desc     : Hold-to-auto-repeat generator for one step direction. A press
//             arms the counter; while the held level stays high, ticks advance
//             it. The first pulse comes after REPEAT_DELAY ticks, then one
//             every REPEAT_RATE ticks. o_fire is a combinational strobe the
//             parent registers.
//  Revision : 1.0  initial release
// ============================================================================
module repeat_gen
  import clock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = C_REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE  = C_REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_press,
  input  logic i_held,
  input  logic i_tick,
  input  logic i_freeze,
  input  logic i_clr,
  output logic o_fire
);

  localparam int unsigned       c_CW    = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [c_CW-1:0]   c_DELAY = c_CW'(REPEAT_DELAY);
  localparam logic [c_CW-1:0]   c_RATE  = c_CW'(REPEAT_RATE);

  logic            r_active;   // armed by a press, dropped when the hold ends
  logic            r_rate;     // 0: waiting out the initial delay, 1: repeating
  logic [c_CW-1:0] r_cnt;
  logic            r_held_q;

  logic [c_CW-1:0] w_lim;
  logic [c_CW-1:0] w_cnt_inc;
  logic            w_fall;
  logic            w_adv;
  logic            w_hit;

  assign w_lim     = r_rate ? c_RATE : c_DELAY;
  assign w_cnt_inc = r_cnt + c_CW'(1);
  assign w_fall    = r_held_q & ~i_held;
  assign w_adv     = r_active & i_tick & i_held & ~i_freeze;
  assign w_hit     = w_adv & (w_cnt_inc == w_lim);
  // A fresh press restarts the sequence, so it suppresses a coincident repeat
  assign o_fire    = w_hit & ~i_press;

  // Repeat counter: restart on press, clear on release or clear, advance on tick
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_rate   <= 1'b0;
      r_cnt    <= '0;
      r_held_q <= 1'b0;
    end else begin
      r_held_q <= i_held;
      if (i_clr) begin
        r_active <= 1'b0;
        r_rate   <= 1'b0;
        r_cnt    <= '0;
      end else if (i_press) begin
        r_active <= 1'b1;
        r_rate   <= 1'b0;
        r_cnt    <= '0;
      end else if (w_fall) begin
        r_active <= 1'b0;
        r_rate   <= 1'b0;
        r_cnt    <= '0;
      end else if (w_adv) begin
        if (w_hit) begin
          r_cnt  <= '0;
          r_rate <= 1'b1;
        end else if (r_cnt != w_lim) begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adjust_mode_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : adjust_mode_fsm
//  Desc     : Front-panel mode/field-select controller. Toggles NORMAL/ADJUST
//             on center, walks a one-hot field select with left/right, emits
//             gated inc/dec steps (with hold-to-repeat) and returns to NORMAL
//             after TIMEOUT_TICKS ticks without activity. All outputs are
//             registered.
//  Revision : 1.0  initial release
// ============================================================================
module adjust_mode_fsm
  import clock_pkg::*;
#(
  parameter int unsigned N_FIELDS      = 4,
  parameter int unsigned TIMEOUT_TICKS = C_TIMEOUT_TICKS_DEF,
  parameter int unsigned REPEAT_DELAY  = C_REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_RATE   = C_REPEAT_RATE_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_tick,
  input  logic                        i_left,
  input  logic                        i_right,
  input  logic                        i_center,
  input  logic                        i_up,
  input  logic                        i_down,
  input  logic                        i_up_held,
  input  logic                        i_down_held,
  output logic                        o_adjust,
  output logic [N_FIELDS-1:0]         o_en,
  output logic [$clog2(N_FIELDS)-1:0] o_sel,
  output logic                        o_inc,
  output logic                        o_dec,
  output logic                        o_timeout
);

  localparam int unsigned        c_SEL_W   = $clog2(N_FIELDS);
  localparam int unsigned        c_TO_W    = $clog2(max2(TIMEOUT_TICKS, REPEAT_DELAY) + 1);
  localparam logic [c_SEL_W-1:0] c_SEL_MAX = c_SEL_W'(N_FIELDS - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LIM  = c_TO_W'(TIMEOUT_TICKS);

  mode_t               r_state;
  logic [c_SEL_W-1:0]  r_sel;
  logic [N_FIELDS-1:0] r_en;
  logic [c_TO_W-1:0]   r_idle;
  logic                r_inc;
  logic                r_dec;
  logic                r_timeout;

  mode_t               w_state_n;
  logic [c_SEL_W-1:0]  w_sel_n;
  logic [N_FIELDS-1:0] w_en_n;
  logic [c_TO_W-1:0]   w_idle_n;
  logic [c_TO_W-1:0]   w_idle_inc;
  logic                w_inc_n;
  logic                w_dec_n;
  logic                w_to_n;
  logic                w_rclr;
  logic                w_in_adj;
  logic                w_press_up;
  logic                w_press_dn;
  logic                w_freeze;
  logic                w_fire_up;
  logic                w_fire_dn;
  logic                w_up_ev;
  logic                w_dn_ev;
  logic                w_act;

  assign w_in_adj   = (r_state == ADJUST);
  // Step presses only arm the repeaters in ADJUST when not leaving it
  assign w_press_up = i_up & w_in_adj & ~i_center;
  assign w_press_dn = i_down & w_in_adj & ~i_center;
  assign w_freeze   = i_up_held & i_down_held;
  assign w_up_ev    = i_up | w_fire_up;
  assign w_dn_ev    = i_down | w_fire_dn;
  assign w_act      = i_left | i_right | w_up_ev | w_dn_ev;
  assign w_idle_inc = r_idle + c_TO_W'(1);

  repeat_gen #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_rep_up (
    .clk      (clk),
    .rst      (rst),
    .i_press  (w_press_up),
    .i_held   (i_up_held),
    .i_tick   (i_tick),
    .i_freeze (w_freeze),
    .i_clr    (w_rclr),
    .o_fire   (w_fire_up)
  );

  repeat_gen #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_rep_dn (
    .clk      (clk),
    .rst      (rst),
    .i_press  (w_press_dn),
    .i_held   (i_down_held),
    .i_tick   (i_tick),
    .i_freeze (w_freeze),
    .i_clr    (w_rclr),
    .o_fire   (w_fire_dn)
  );

  // Next-state, field select, step pulses and inactivity timeout
  always_comb begin
    w_state_n = r_state;
    w_sel_n   = r_sel;
    w_idle_n  = r_idle;
    w_inc_n   = 1'b0;
    w_dec_n   = 1'b0;
    w_to_n    = 1'b0;
    w_rclr    = 1'b0;
    case (r_state)
      NORMAL: begin
        w_rclr   = 1'b1;
        w_idle_n = '0;
        if (i_center) begin
          w_state_n = ADJUST;
          w_sel_n   = '0;
        end
      end
      ADJUST: begin
        if (i_center) begin
          // Leaving drops any navigation or step in the same cycle
          w_state_n = NORMAL;
          w_rclr    = 1'b1;
          w_idle_n  = '0;
        end else begin
          if (i_right & ~i_left) begin
            w_sel_n = (r_sel == c_SEL_MAX) ? '0 : r_sel + c_SEL_W'(1);
          end else if (i_left & ~i_right) begin
            w_sel_n = (r_sel == '0) ? c_SEL_MAX : r_sel - c_SEL_W'(1);
          end
          w_inc_n = w_up_ev & ~w_dn_ev;
          w_dec_n = w_dn_ev & ~w_up_ev;
          if (w_act) begin
            w_idle_n = '0;
          end else if (i_tick) begin
            if (w_idle_inc == c_TO_LIM) begin
              w_state_n = NORMAL;
              w_rclr    = 1'b1;
              w_idle_n  = '0;
              w_to_n    = 1'b1;
            end else if (r_idle != c_TO_LIM) begin
              w_idle_n = w_idle_inc;
            end
          end
        end
      end
      default: begin
        w_state_n = NORMAL;
        w_rclr    = 1'b1;
        w_idle_n  = '0;
      end
    endcase
    w_en_n = (w_state_n == ADJUST) ? N_FIELDS'(onehot(32'(w_sel_n), N_FIELDS)) : '0;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= NORMAL;
      r_sel     <= '0;
      r_en      <= '0;
      r_idle    <= '0;
      r_inc     <= 1'b0;
      r_dec     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_sel     <= w_sel_n;
      r_en      <= w_en_n;
      r_idle    <= w_idle_n;
      r_inc     <= w_inc_n;
      r_dec     <= w_dec_n;
      r_timeout <= w_to_n;
    end
  end

  assign o_adjust  = (r_state == ADJUST);
  assign o_en      = r_en;
  assign o_sel     = r_sel;
  assign o_inc     = r_inc;
  assign o_dec     = r_dec;
  assign o_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_adjust_mode_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adjust_mode_fsm
//  Desc     : Self-checking bench for adjust_mode_fsm with directed scenarios
//             and randomized stimulus against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adjust_mode_fsm;

  localparam int N     = 4;
  localparam int TO    = 20;
  localparam int DELAY = 5;
  localparam int RATE  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;
  logic       up = 1'b0, down = 1'b0, up_held = 1'b0, down_held = 1'b0;
  logic       adjust, inc, dec, timeout;
  logic [3:0] en;
  logic [1:0] sel;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: mode, field, idle ticks, ticks since press (-1 idle)
  int         m_adj, m_sel, m_idle;
  int         m_rt[2];
  bit         m_hq[2];
  bit         e_inc, e_dec, e_to;
  logic [3:0] e_en;

  adjust_mode_fsm #(
    .N_FIELDS      (N),
    .TIMEOUT_TICKS (TO),
    .REPEAT_DELAY  (DELAY),
    .REPEAT_RATE   (RATE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (tick),
    .i_left      (left),
    .i_right     (right),
    .i_center    (center),
    .i_up        (up),
    .i_down      (down),
    .i_up_held   (up_held),
    .i_down_held (down_held),
    .o_adjust    (adjust),
    .o_en        (en),
    .o_sel       (sel),
    .o_inc       (inc),
    .o_dec       (dec),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Apply one clock of the current inputs to the model
  task automatic model_step();
    bit prs[2], hld[2], fire[2];
    bit upe, dne, act;
    prs[0] = up; prs[1] = down; hld[0] = up_held; hld[1] = down_held;
    fire[0] = 0; fire[1] = 0;
    e_inc = 0; e_dec = 0; e_to = 0;
    if (rst) begin
      m_adj = 0; m_sel = 0; m_idle = 0;
      m_rt[0] = -1; m_rt[1] = -1; m_hq[0] = 0; m_hq[1] = 0;
    end else begin
      if (m_adj == 0) begin
        m_rt[0] = -1; m_rt[1] = -1; m_idle = 0;
        if (center) begin m_adj = 1; m_sel = 0; end
      end else if (center) begin
        m_adj = 0; m_rt[0] = -1; m_rt[1] = -1; m_idle = 0;
      end else begin
        if (right && !left) m_sel = (m_sel + 1) % N;
        else if (left && !right) m_sel = (m_sel + N - 1) % N;
        for (int d = 0; d < 2; d++) begin
          if (prs[d]) m_rt[d] = 0;
          else if (m_hq[d] && !hld[d]) m_rt[d] = -1;
          else if (m_rt[d] >= 0 && tick && hld[d] && !(hld[0] && hld[1])) begin
            m_rt[d]++;
            fire[d] = (m_rt[d] == DELAY) || (m_rt[d] > DELAY && ((m_rt[d] - DELAY) % RATE) == 0);
          end
        end
        upe = up | fire[0];
        dne = down | fire[1];
        e_inc = upe && !dne;
        e_dec = dne && !upe;
        act = left | right | upe | dne;
        if (act) m_idle = 0;
        else if (tick) begin
          m_idle++;
          if (m_idle >= TO) begin
            m_adj = 0; m_idle = 0; e_to = 1; m_rt[0] = -1; m_rt[1] = -1;
          end
        end
      end
      m_hq[0] = hld[0]; m_hq[1] = hld[1];
    end
    e_en = (m_adj != 0) ? 4'(1 << m_sel) : 4'b0;
  endtask

  // One clock: update model, clock the DUT, sample #1 later, clear pulse inputs
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    tick = 0; left = 0; right = 0; center = 0; up = 0; down = 0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1; step();
      step();
    end
  endtask

  task automatic test_reset();
    rst = 0;
    center = 1; step();
    right = 1; step();
    right = 1; step();
    n_total++;
    if (sel !== 2'd2 || adjust !== 1'b1) begin
      n_bad++; $display("FAIL reset_setup: adjust=%0b sel=%0d need adjust=1 sel=2", adjust, sel);
    end
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      center = (i == 0); up = 1; tick = 1;
      step();
      n_total++;
      if (adjust !== 1'b0 || en !== 4'b0 || sel !== 2'd0 || inc !== 1'b0 || dec !== 1'b0 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state: adjust=%0b en=%b sel=%0d inc=%0b dec=%0b to=%0b need all zero",
                 adjust, en, sel, inc, dec, timeout);
      end
    end
    rst = 0;
    step();
  endtask

  task automatic test_nav();
    int exp_r[5] = '{1, 2, 3, 0, 1};
    int exp_l[2] = '{3, 2};
    center = 1; step();
    n_total++;
    if (adjust !== 1'b1 || sel !== 2'd0 || en !== 4'b0001) begin
      n_bad++; $display("FAIL enter_adjust: adjust=%0b sel=%0d en=%b need 1/0/0001", adjust, sel, en);
    end
    for (int i = 0; i < 5; i++) begin
      right = 1; step();
      n_total++;
      if (sel !== 2'(exp_r[i])) begin
        n_bad++; $display("FAIL nav_right%0d: sel=%0d need %0d", i, sel, exp_r[i]);
      end
    end
    n_total++;
    if (en !== 4'b0010) begin
      n_bad++; $display("FAIL nav_en: en=%b need 0010", en);
    end
    repeat (3) begin right = 1; step(); end
    for (int i = 0; i < 2; i++) begin
      left = 1; step();
      n_total++;
      if (sel !== 2'(exp_l[i]) || en !== 4'(1 << exp_l[i])) begin
        n_bad++; $display("FAIL nav_left%0d: sel=%0d en=%b need sel %0d", i, sel, en, exp_l[i]);
      end
    end
    left = 1; right = 1; step();
    n_total++;
    if (sel !== 2'd2) begin
      n_bad++; $display("FAIL nav_both: sel=%0d need 2", sel);
    end
  endtask

  task automatic test_step();
    up = 1; step();
    n_total++;
    if (inc !== 1'b1 || dec !== 1'b0) begin
      n_bad++; $display("FAIL step_up: inc=%0b dec=%0b need 1/0", inc, dec);
    end
    step();
    n_total++;
    if (inc !== 1'b0) begin
      n_bad++; $display("FAIL step_width: inc=%0b need 0", inc);
    end
    up = 1; down = 1; step();
    n_total++;
    if (inc !== 1'b0 || dec !== 1'b0) begin
      n_bad++; $display("FAIL step_both: inc=%0b dec=%0b need 0/0", inc, dec);
    end
    down = 1; step();
    n_total++;
    if (dec !== 1'b1 || inc !== 1'b0) begin
      n_bad++; $display("FAIL step_down: inc=%0b dec=%0b need 0/1", inc, dec);
    end
    right = 1; up = 1; step();
    n_total++;
    if (inc !== 1'b1 || sel !== 2'd3 || en !== 4'b1000) begin
      n_bad++; $display("FAIL step_newfield: inc=%0b sel=%0d en=%b need 1/3/1000", inc, sel, en);
    end
    step();
  endtask

  task automatic test_timeout();
    tick_n(TO - 1);
    n_total++;
    if (adjust !== 1'b1 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_early: adjust=%0b to=%0b need 1/0", adjust, timeout);
    end
    tick = 1; step();
    n_total++;
    if (timeout !== 1'b1 || adjust !== 1'b0 || en !== 4'b0) begin
      n_bad++; $display("FAIL timeout_fire: to=%0b adjust=%0b en=%b need 1/0/0000", timeout, adjust, en);
    end
    step();
    n_total++;
    if (timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_width: to=%0b need 0", timeout);
    end
    center = 1; step();
    tick_n(TO - 2);
    tick = 1; right = 1; step();
    n_total++;
    if (adjust !== 1'b1 || timeout !== 1'b0) begin
      n_bad++; $display("FAIL timeout_button_wins: adjust=%0b to=%0b need 1/0", adjust, timeout);
    end
    tick_n(TO - 1);
    tick = 1; step();
    n_total++;
    if (timeout !== 1'b1 || adjust !== 1'b0) begin
      n_bad++; $display("FAIL timeout_restart: to=%0b adjust=%0b need 1/0", timeout, adjust);
    end
  endtask

  task automatic test_repeat();
    int got = 0;
    int want = (1 << 5) | (1 << 7) | (1 << 9) | (1 << 11);
    bit extra = 0;
    center = 1; step();
    up = 1; up_held = 1; step();
    n_total++;
    if (inc !== 1'b1) begin
      n_bad++; $display("FAIL repeat_press: inc=%0b need 1", inc);
    end
    for (int k = 1; k <= 12; k++) begin
      tick = 1; step();
      if (inc === 1'b1) got |= (1 << k);
      if (timeout !== 1'b0 || adjust !== 1'b1) extra = 1;
      step();
      if (inc !== 1'b0) extra = 1;
    end
    n_total++;
    if (got != want) begin
      n_bad++; $display("FAIL repeat_ticks: inc tick mask=%h need %h", got, want);
    end
    n_total++;
    if (extra) begin
      n_bad++; $display("FAIL repeat_clean: stray inc/timeout/exit seen=1 need 0");
    end
    up_held = 0; step();
  endtask

  task automatic test_center_nav();
    int s;
    right = 1; step();
    s = m_sel;
    center = 1; right = 1; step();
    n_total++;
    if (adjust !== 1'b0 || sel !== 2'(s) || en !== 4'b0) begin
      n_bad++; $display("FAIL center_nav: adjust=%0b sel=%0d en=%b need 0/%0d/0000", adjust, sel, en, s);
    end
    up = 1; up_held = 1; step();
    n_total++;
    if (inc !== 1'b0 || en !== 4'b0) begin
      n_bad++; $display("FAIL normal_up: inc=%0b en=%b need 0/0000", inc, en);
    end
    up_held = 0; step();
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 30; seg++) begin
      bit quiet = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < 100; c++) begin
        rst    = ($urandom_range(0, 299) == 0);
        tick   = ($urandom_range(0, 2) == 0);
        if (!quiet) begin
          left   = ($urandom_range(0, 9) == 0);
          right  = ($urandom_range(0, 9) == 0);
          up     = ($urandom_range(0, 9) == 0);
          down   = ($urandom_range(0, 9) == 0);
          center = ($urandom_range(0, 39) == 0);
        end else begin
          center = ($urandom_range(0, 99) == 0);
        end
        if ($urandom_range(0, 14) == 0) up_held = ~up_held;
        if ($urandom_range(0, 19) == 0) down_held = ~down_held;
        step();
        n_total++;
        if (adjust !== 1'(m_adj) || sel !== 2'(m_sel) || en !== e_en ||
            inc !== e_inc || dec !== e_dec || timeout !== e_to) begin
          n_bad++;
          $display("FAIL random seg%0d cyc%0d: got adj=%0b sel=%0d en=%b inc=%0b dec=%0b to=%0b need %0d/%0d/%b/%0b/%0b/%0b",
                   seg, c, adjust, sel, en, inc, dec, timeout, m_adj, m_sel, e_en, e_inc, e_dec, e_to);
        end
      end
    end
    rst = 0; up_held = 0; down_held = 0;
    step();
  endtask

  initial begin
    rst = 1;
    step();
    step();
    test_reset();
    test_nav();
    test_step();
    test_timeout();
    test_repeat();
    test_center_nav();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
